// File: rtl/homography_pkg.sv
// Shared widths and FSM encoding for the homography arbiter.
// Imported by the arbiter top and its tag FIFO.
package homography_pkg;
  localparam int COORD_W = 10;
  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;
  localparam int ID_W = 1;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
endpackage

// File: rtl/homography_arbiter_tag_fifo.sv
// Owner-tag FIFO: head readable combinationally,
// push and pop may coincide at any fill level.
import homography_pkg::*;

module tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W = ID_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Storage write; full+pop reads the old head before overwrite.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer advance, both wrap at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  end
endmodule

// File: rtl/homography_arbiter.sv
// Round-robin sharing of one homography engine between two
// requesters, with in-order result routing and drain/halt.
import homography_pkg::*;

module homography_arbiter #(
  parameter int DEPTH = 8,
  parameter int CW = 4
) (
  input  logic               clk_25,
  input  logic               rst,
  input  logic               en,
  input  logic               req0_start,
  input  logic [COORD_W-1:0] req0_x,
  input  logic [COORD_W-1:0] req0_y,
  output logic               req0_gnt,
  input  logic               req1_start,
  input  logic [COORD_W-1:0] req1_x,
  input  logic [COORD_W-1:0] req1_y,
  output logic               req1_gnt,
  output logic               ret0_valid,
  output logic [COORD_W-1:0] ret0_x,
  output logic [COORD_W-1:0] ret0_y,
  output logic [R_W-1:0]     ret0_r,
  output logic [G_W-1:0]     ret0_g,
  output logic [B_W-1:0]     ret0_b,
  output logic               ret1_valid,
  output logic [COORD_W-1:0] ret1_x,
  output logic [COORD_W-1:0] ret1_y,
  output logic [R_W-1:0]     ret1_r,
  output logic [G_W-1:0]     ret1_g,
  output logic [B_W-1:0]     ret1_b,
  output logic               eng_start,
  output logic [COORD_W-1:0] eng_query_x,
  output logic [COORD_W-1:0] eng_query_y,
  input  logic               eng_ready,
  input  logic [COORD_W-1:0] eng_return_x,
  input  logic [COORD_W-1:0] eng_return_y,
  input  logic [R_W-1:0]     eng_r,
  input  logic [G_W-1:0]     eng_g,
  input  logic [B_W-1:0]     eng_b,
  output logic [CW-1:0]      outstanding,
  output logic               drained,
  output logic               err_underflow
);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic            rr_last;
  logic            can_grant;
  logic            accept;
  logic            pop;
  logic [ID_W-1:0] head;
  logic [CW-1:0]   out_next;

  assign can_grant = !rst && state == S_RUN && outstanding < FULL;
  assign req0_gnt = can_grant && req0_start &&
                    (!req1_start || rr_last);
  assign req1_gnt = can_grant && req1_start &&
                    (!req0_start || !rr_last);
  assign accept = req0_gnt || req1_gnt;
  assign pop = eng_ready && outstanding != '0;
  assign drained = state == S_HALT;

  tag_fifo #(.DEPTH(DEPTH), .W(ID_W)) u_tags (
    .clk      (clk_25),
    .rst      (rst),
    .push     (accept),
    .push_data(req1_gnt),
    .pop      (pop),
    .head     (head)
  );

  // In-flight count after this cycle's accept and pop.
  always_comb begin
    out_next = outstanding;
    if (accept && !pop) out_next = outstanding + CW'(1);
    else if (!accept && pop) out_next = outstanding - CW'(1);
  end

  // Run/drain/halt sequencing.
  always_comb begin
    state_next = state;
    case (state)
      S_RUN:   if (!en) state_next = S_DRAIN;
      S_DRAIN: begin
        if (en) state_next = S_RUN;
        else if (out_next == '0) state_next = S_HALT;
      end
      S_HALT:  if (en) state_next = S_RUN;
      default: state_next = S_RUN;
    endcase
  end

  // Control state: FSM, round-robin pointer, counter, error flag.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      state <= S_RUN;
      rr_last <= 1'b1;
      outstanding <= '0;
      err_underflow <= 1'b0;
    end else begin
      state <= state_next;
      outstanding <= out_next;
      if (accept) rr_last <= req1_gnt;
      if (eng_ready && outstanding == '0) err_underflow <= 1'b1;
    end
  end

  // Issue the accepted query one cycle after the grant.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      eng_start <= 1'b0;
      eng_query_x <= '0;
      eng_query_y <= '0;
    end else begin
      eng_start <= accept;
      if (accept) begin
        eng_query_x <= req1_gnt ? req1_x : req0_x;
        eng_query_y <= req1_gnt ? req1_y : req0_y;
      end
    end
  end

  // Route each popped result to the requester that owns it.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      ret0_valid <= 1'b0;
      ret0_x <= '0;
      ret0_y <= '0;
      ret0_r <= '0;
      ret0_g <= '0;
      ret0_b <= '0;
      ret1_valid <= 1'b0;
      ret1_x <= '0;
      ret1_y <= '0;
      ret1_r <= '0;
      ret1_g <= '0;
      ret1_b <= '0;
    end else begin
      ret0_valid <= pop && !head;
      ret1_valid <= pop && head;
      if (pop && !head) begin
        ret0_x <= eng_return_x;
        ret0_y <= eng_return_y;
        ret0_r <= eng_r;
        ret0_g <= eng_g;
        ret0_b <= eng_b;
      end
      if (pop && head) begin
        ret1_x <= eng_return_x;
        ret1_y <= eng_return_y;
        ret1_r <= eng_r;
        ret1_g <= eng_g;
        ret1_b <= eng_b;
      end
    end
  end
endmodule

// File: tb/tb_homography_arbiter.sv
// Directed bench for homography_arbiter.
// Inputs change 1ns after the rising edge; outputs checked there too.
module tb_homography_arbiter;
  logic       clk_25 = 0;
  logic       rst = 1;
  logic       en = 1;
  logic       req0_start = 0;
  logic [9:0] req0_x = 0;
  logic [9:0] req0_y = 0;
  logic       req0_gnt;
  logic       req1_start = 0;
  logic [9:0] req1_x = 0;
  logic [9:0] req1_y = 0;
  logic       req1_gnt;
  logic       ret0_valid;
  logic [9:0] ret0_x;
  logic [9:0] ret0_y;
  logic [4:0] ret0_r;
  logic [5:0] ret0_g;
  logic [4:0] ret0_b;
  logic       ret1_valid;
  logic [9:0] ret1_x;
  logic [9:0] ret1_y;
  logic [4:0] ret1_r;
  logic [5:0] ret1_g;
  logic [4:0] ret1_b;
  logic       eng_start;
  logic [9:0] eng_query_x;
  logic [9:0] eng_query_y;
  logic       eng_ready = 0;
  logic [9:0] eng_return_x = 0;
  logic [9:0] eng_return_y = 0;
  logic [4:0] eng_r = 0;
  logic [5:0] eng_g = 0;
  logic [4:0] eng_b = 0;
  logic [3:0] outstanding;
  logic       drained;
  logic       err_underflow;

  int vecs = 0;
  int errs = 0;

  always #5 clk_25 = ~clk_25;

  homography_arbiter #(.DEPTH(8), .CW(4)) dut (
    .clk_25(clk_25), .rst(rst), .en(en),
    .req0_start(req0_start), .req0_x(req0_x), .req0_y(req0_y),
    .req0_gnt(req0_gnt),
    .req1_start(req1_start), .req1_x(req1_x), .req1_y(req1_y),
    .req1_gnt(req1_gnt),
    .ret0_valid(ret0_valid), .ret0_x(ret0_x), .ret0_y(ret0_y),
    .ret0_r(ret0_r), .ret0_g(ret0_g), .ret0_b(ret0_b),
    .ret1_valid(ret1_valid), .ret1_x(ret1_x), .ret1_y(ret1_y),
    .ret1_r(ret1_r), .ret1_g(ret1_g), .ret1_b(ret1_b),
    .eng_start(eng_start), .eng_query_x(eng_query_x),
    .eng_query_y(eng_query_y), .eng_ready(eng_ready),
    .eng_return_x(eng_return_x), .eng_return_y(eng_return_y),
    .eng_r(eng_r), .eng_g(eng_g), .eng_b(eng_b),
    .outstanding(outstanding), .drained(drained),
    .err_underflow(err_underflow)
  );

  task automatic tick;
    @(posedge clk_25);
    #1;
  endtask

  task automatic do_reset;
    rst = 1;
    en = 1;
    req0_start = 0;
    req1_start = 0;
    eng_ready = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    vecs++;
    if ({req0_gnt, req1_gnt, eng_start, ret0_valid, ret1_valid,
         drained, err_underflow} !== 7'b0) begin
      errs++;
      $display("FAIL reset_flags: got %b want 0",
        {req0_gnt, req1_gnt, eng_start, ret0_valid, ret1_valid,
         drained, err_underflow});
    end
    vecs++;
    if ({eng_query_x, eng_query_y, ret0_x, ret1_x, outstanding}
        !== 44'd0) begin
      errs++;
      $display("FAIL reset_data: got q=%0d,%0d r0x=%0d r1x=%0d out=%0d want 0",
        eng_query_x, eng_query_y, ret0_x, ret1_x, outstanding);
    end
  endtask

  task automatic test_single;
    do_reset();
    req0_start = 1;
    req0_x = 100;
    req0_y = 50;
    #1;
    vecs++;
    if (req0_gnt !== 1 || req1_gnt !== 0) begin
      errs++;
      $display("FAIL single_gnt: got %b%b want 10", req0_gnt, req1_gnt);
    end
    tick();
    req0_start = 0;
    vecs++;
    if (eng_start !== 1 || eng_query_x !== 100 || eng_query_y !== 50
        || outstanding !== 1) begin
      errs++;
      $display("FAIL single_issue: got s=%b q=%0d,%0d out=%0d want 1 100,50 1",
        eng_start, eng_query_x, eng_query_y, outstanding);
    end
    tick();
    tick();
    tick();
    vecs++;
    if (eng_start !== 0 || eng_query_x !== 100) begin
      errs++;
      $display("FAIL single_hold: got s=%b qx=%0d want 0 100",
        eng_start, eng_query_x);
    end
    eng_ready = 1;
    eng_return_x = 100;
    eng_return_y = 50;
    eng_r = 3;
    eng_g = 7;
    eng_b = 9;
    tick();
    eng_ready = 0;
    vecs++;
    if (ret0_valid !== 1 || ret1_valid !== 0 || ret0_x !== 100
        || ret0_y !== 50 || ret0_r !== 3 || ret0_g !== 7
        || ret0_b !== 9 || outstanding !== 0) begin
      errs++;
      $display("FAIL single_ret: got v=%b%b %0d,%0d rgb=%0d,%0d,%0d out=%0d",
        ret0_valid, ret1_valid, ret0_x, ret0_y, ret0_r, ret0_g,
        ret0_b, outstanding);
    end
    eng_return_x = 999;
    tick();
    vecs++;
    if (ret0_valid !== 0 || ret0_x !== 100) begin
      errs++;
      $display("FAIL single_after: got v=%b x=%0d want 0 100",
        ret0_valid, ret0_x);
    end
  endtask

  task automatic test_contention;
    do_reset();
    req0_start = 1;
    req0_x = 10;
    req0_y = 11;
    req1_start = 1;
    req1_x = 20;
    req1_y = 21;
    for (int i = 0; i < 4; i++) begin
      #1;
      vecs++;
      if (req0_gnt !== (i % 2 == 0) || req1_gnt !== (i % 2 == 1)) begin
        errs++;
        $display("FAIL cont_gnt[%0d]: got %b%b want %b%b", i,
          req0_gnt, req1_gnt, i % 2 == 0, i % 2 == 1);
      end
      tick();
      vecs++;
      if (eng_start !== 1 || eng_query_x !== (i % 2 ? 20 : 10)) begin
        errs++;
        $display("FAIL cont_issue[%0d]: got s=%b qx=%0d want 1 %0d", i,
          eng_start, eng_query_x, i % 2 ? 20 : 10);
      end
    end
    req0_start = 0;
    req1_start = 0;
    for (int i = 0; i < 4; i++) begin
      eng_ready = 1;
      eng_return_x = 10'(300 + i);
      eng_return_y = 10'(400 + i);
      tick();
      vecs++;
      if (i % 2 == 0) begin
        if (ret0_valid !== 1 || ret1_valid !== 0
            || ret0_x !== 300 + i || ret0_y !== 400 + i) begin
          errs++;
          $display("FAIL cont_ret[%0d]: got v=%b%b x=%0d want 10 %0d", i,
            ret0_valid, ret1_valid, ret0_x, 300 + i);
        end
      end else begin
        if (ret1_valid !== 1 || ret0_valid !== 0
            || ret1_x !== 300 + i || ret1_y !== 400 + i) begin
          errs++;
          $display("FAIL cont_ret[%0d]: got v=%b%b x=%0d want 01 %0d", i,
            ret0_valid, ret1_valid, ret1_x, 300 + i);
        end
      end
    end
    eng_ready = 0;
    vecs++;
    if (outstanding !== 0) begin
      errs++;
      $display("FAIL cont_out: got %0d want 0", outstanding);
    end
  endtask

  task automatic test_full;
    do_reset();
    req0_start = 1;
    req0_x = 1;
    req0_y = 2;
    for (int i = 0; i < 8; i++) begin
      #1;
      vecs++;
      if (req0_gnt !== 1) begin
        errs++;
        $display("FAIL full_fill[%0d]: got gnt %b want 1", i, req0_gnt);
      end
      tick();
    end
    tick();
    vecs++;
    if (outstanding !== 8 || req0_gnt !== 0) begin
      errs++;
      $display("FAIL full_stall: got out=%0d gnt=%b want 8 0",
        outstanding, req0_gnt);
    end
    eng_ready = 1;
    eng_return_x = 55;
    #1;
    vecs++;
    if (req0_gnt !== 0) begin
      errs++;
      $display("FAIL full_pop_gnt: got %b want 0", req0_gnt);
    end
    tick();
    eng_ready = 0;
    #1;
    vecs++;
    if (ret0_valid !== 1 || ret0_x !== 55 || outstanding !== 7
        || req0_gnt !== 1) begin
      errs++;
      $display("FAIL full_resume: got v=%b x=%0d out=%0d gnt=%b want 1 55 7 1",
        ret0_valid, ret0_x, outstanding, req0_gnt);
    end
  endtask

  task automatic test_drain;
    do_reset();
    req0_start = 1;
    tick();
    tick();
    tick();
    req0_start = 0;
    en = 0;
    tick();
    req0_start = 1;
    #1;
    vecs++;
    if (req0_gnt !== 0 || outstanding !== 3 || drained !== 0) begin
      errs++;
      $display("FAIL drain_block: got gnt=%b out=%0d dr=%b want 0 3 0",
        req0_gnt, outstanding, drained);
    end
    for (int i = 0; i < 3; i++) begin
      eng_ready = 1;
      tick();
      vecs++;
      if (drained !== (i == 2) || ret0_valid !== 1) begin
        errs++;
        $display("FAIL drain_pop[%0d]: got dr=%b v=%b want %b 1", i,
          drained, ret0_valid, i == 2);
      end
    end
    eng_ready = 0;
    #1;
    vecs++;
    if (req0_gnt !== 0 || outstanding !== 0) begin
      errs++;
      $display("FAIL halt_block: got gnt=%b out=%0d want 0 0",
        req0_gnt, outstanding);
    end
    en = 1;
    #1;
    vecs++;
    if (req0_gnt !== 0) begin
      errs++;
      $display("FAIL halt_en_same: got gnt=%b want 0", req0_gnt);
    end
    tick();
    vecs++;
    if (req0_gnt !== 1 || drained !== 0) begin
      errs++;
      $display("FAIL halt_resume: got gnt=%b dr=%b want 1 0",
        req0_gnt, drained);
    end
    req0_start = 0;
  endtask

  task automatic test_underflow;
    do_reset();
    eng_ready = 1;
    tick();
    eng_ready = 0;
    vecs++;
    if (err_underflow !== 1 || ret0_valid !== 0 || ret1_valid !== 0
        || outstanding !== 0) begin
      errs++;
      $display("FAIL uflow_set: got err=%b v=%b%b out=%0d want 1 00 0",
        err_underflow, ret0_valid, ret1_valid, outstanding);
    end
    req0_start = 1;
    tick();
    req0_start = 0;
    tick();
    vecs++;
    if (err_underflow !== 1 || outstanding !== 1) begin
      errs++;
      $display("FAIL uflow_sticky: got err=%b out=%0d want 1 1",
        err_underflow, outstanding);
    end
    do_reset();
    #1;
    vecs++;
    if (err_underflow !== 0 || outstanding !== 0 || eng_start !== 0) begin
      errs++;
      $display("FAIL uflow_rst: got err=%b out=%0d s=%b want 0 0 0",
        err_underflow, outstanding, eng_start);
    end
    req0_start = 1;
    req1_start = 1;
    #1;
    vecs++;
    if (req0_gnt !== 1 || req1_gnt !== 0) begin
      errs++;
      $display("FAIL uflow_rr: got %b%b want 10", req0_gnt, req1_gnt);
    end
    req0_start = 0;
    req1_start = 0;
  endtask

  task automatic test_simultaneous;
    do_reset();
    req1_start = 1;
    tick();
    tick();
    tick();
    req1_start = 0;
    req0_start = 1;
    req0_x = 7;
    req0_y = 8;
    eng_ready = 1;
    eng_return_x = 77;
    #1;
    vecs++;
    if (req0_gnt !== 1 || outstanding !== 3) begin
      errs++;
      $display("FAIL simul_gnt: got gnt=%b out=%0d want 1 3",
        req0_gnt, outstanding);
    end
    tick();
    req0_start = 0;
    eng_ready = 0;
    vecs++;
    if (outstanding !== 3 || eng_start !== 1 || eng_query_x !== 7
        || ret1_valid !== 1 || ret0_valid !== 0 || ret1_x !== 77) begin
      errs++;
      $display("FAIL simul_both: got out=%0d s=%b qx=%0d v=%b%b x=%0d",
        outstanding, eng_start, eng_query_x, ret0_valid, ret1_valid,
        ret1_x);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_drain();
    test_underflow();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
